// File: rtl/multi_pkg.sv
// Shared constants for the multiplier slice.
package multi_pkg;

  // Default operand width of the array multiplier.
  localparam int MULTI_WIDTH = 4;

endpackage

// File: rtl/multi_full_adder.sv
// One-bit full adder cell used to build the multiplier's adder array.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/multi.sv
// Unsigned WIDTH x WIDTH structural array multiplier (shift-and-add).
// Gives the truncated combinational product, an overflow flag and a
// registered full-width product. WIDTH must be at least 2.
module multi
  import multi_pkg::*;
#(
  parameter int WIDTH = MULTI_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [WIDTH-1:0]   Pcirc,
  output logic               ovf,
  output logic [2*WIDTH-1:0] P_q
);

  // pp[i][j] = a[j] & b[i]
  logic [WIDTH-1:0][WIDTH-1:0] pp;
  // acc[r]: running partial sum shifted right by one, entering row r+1
  logic [WIDTH-1:0][WIDTH-1:0] acc;
  logic [WIDTH-1:1][WIDTH-1:0] sum;
  logic [WIDTH-1:1][WIDTH:0]   cy;
  logic [2*WIDTH-1:0]          p;

  genvar i, r, j;

  generate
    for (i = 0; i < WIDTH; i++) begin : g_pp
      assign pp[i] = a & {WIDTH{b[i]}};
    end
  endgenerate

  // Row 0 is the bare first partial product; its LSB is final.
  assign p[0]   = pp[0][0];
  assign acc[0] = {1'b0, pp[0][WIDTH-1:1]};

  // Each row adds the next partial product to the shifted running sum;
  // the row's carry-out becomes the MSB of the operand for the next row.
  generate
    for (r = 1; r < WIDTH; r++) begin : g_row
      assign cy[r][0] = 1'b0;
      for (j = 0; j < WIDTH; j++) begin : g_col
        full_adder u_fa (
          .a    (acc[r-1][j]),
          .b    (pp[r][j]),
          .cin  (cy[r][j]),
          .s    (sum[r][j]),
          .cout (cy[r][j+1])
        );
      end
      assign p[r]   = sum[r][0];
      assign acc[r] = {cy[r][WIDTH], sum[r][WIDTH-1:1]};
    end
  endgenerate

  // Upper half of the product is whatever the last row leaves behind.
  assign p[2*WIDTH-1:WIDTH] = acc[WIDTH-1];

  assign Pcirc = p[WIDTH-1:0];
  assign ovf   = |p[2*WIDTH-1:WIDTH];

  // Register the full product for clocked consumers; reset clears it.
  always_ff @(posedge clk) begin
    if (rst) P_q <= '0;
    else     P_q <= p;
  end

endmodule

// File: tb/tb_multi.sv
// Self-checking bench for multi: directed cases, reset behaviour,
// exhaustive sweep and random stimulus against an arithmetic model.
module tb_multi;

  localparam int W = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [W-1:0]   a = '0;
  logic [W-1:0]   b = '0;
  logic [W-1:0]   Pcirc;
  logic           ovf;
  logic [2*W-1:0] P_q;

  int n_chk  = 0;
  int n_fail = 0;

  multi #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .a     (a),
    .b     (b),
    .Pcirc (Pcirc),
    .ovf   (ovf),
    .P_q   (P_q)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Drive one operand pair with the given reset level, check the
  // combinational outputs, then the registered product after the edge.
  task automatic apply(input int av, input int bv, input bit r, input string tag);
    int prod;
    @(negedge clk);
    a   = W'(av);
    b   = W'(bv);
    rst = r;
    prod = av * bv;
    #1;
    check({tag, ".Pcirc"}, 32'(Pcirc), 32'(prod % (1 << W)));
    check({tag, ".ovf"},   32'(ovf),   32'(prod > (1 << W) - 1));
    @(posedge clk);
    #1;
    check({tag, ".P_q"},   32'(P_q),   r ? 32'd0 : 32'(prod));
  endtask

  initial begin
    // Reset state
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset.P_q", 32'(P_q), 32'd0);

    // Directed cases
    apply(3, 2, 1'b0, "d3x2");
    apply(4, 5, 1'b0, "d4x5");
    apply(7, 7, 1'b0, "d7x7");
    apply(15, 15, 1'b0, "d15x15");
    apply(8, 0, 1'b0, "d8x0");
    apply(0, 9, 1'b0, "d0x9");

    // Mid-stream reset with max operands, then release loads current P
    apply(15, 15, 1'b1, "rst15x15");
    apply(15, 15, 1'b0, "rel15x15");
    apply(11, 13, 1'b0, "d11x13");

    // Exhaustive sweep
    for (int ia = 0; ia < (1 << W); ia++)
      for (int ib = 0; ib < (1 << W); ib++)
        apply(ia, ib, 1'b0, "sweep");

    // Random stimulus with occasional reset
    for (int k = 0; k < 200; k++)
      apply(int'($urandom_range((1 << W) - 1)), int'($urandom_range((1 << W) - 1)),
            ($urandom_range(7) == 0), "rand");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
